// File: rtl/imem_prefetch_buffer_if.sv
// Interfaces for imem_prefetch_buffer.
//   imem_fetch_if : core-side fetch port (core is master, prefetch buffer is slave)
//   imem_bus_if   : instruction memory bus (prefetch buffer is master, memory is slave)
interface imem_fetch_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PARCEL_SIZE = 32
);
    localparam int unsigned VW = PARCEL_SIZE / 16;

    logic [XLEN-1:0]        if_nxt_pc;
    logic                   if_stall_nxt_pc;
    logic                   if_stall;
    logic                   if_flush;
    logic [PARCEL_SIZE-1:0] if_parcel;
    logic [XLEN-1:0]        if_parcel_pc;
    logic [VW-1:0]          if_parcel_valid;
    logic                   if_parcel_misaligned;
    logic                   if_parcel_page_fault;

    modport master (
        output if_nxt_pc, if_stall, if_flush,
        input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
               if_parcel_misaligned, if_parcel_page_fault
    );

    modport slave (
        input  if_nxt_pc, if_stall, if_flush,
        output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
               if_parcel_misaligned, if_parcel_page_fault
    );
endinterface

interface imem_bus_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PARCEL_SIZE = 32
);
    logic                   mem_req;
    logic [XLEN-1:0]        mem_adr;
    logic                   mem_stall;
    logic                   mem_ack;
    logic [PARCEL_SIZE-1:0] mem_q;
    logic                   mem_page_fault;

    modport master (
        output mem_req, mem_adr,
        input  mem_stall, mem_ack, mem_q, mem_page_fault
    );

    modport slave (
        input  mem_req, mem_adr,
        output mem_stall, mem_ack, mem_q, mem_page_fault
    );
endinterface

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: issues fetch addresses to the instruction bus, keeps up to
// DEPTH requests in flight/buffered, and presents in-order responses to the core.
// Optional feature macro: IMEM_PREFETCH_BYPASS_EN (response forwarded to the core in the
// ack cycle when the buffer is empty).
module imem_prefetch_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PARCEL_SIZE = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HAS_RVC     = 0
) (
    input  logic        clk,
    input  logic        rstn,
    imem_fetch_if.slave fetch,
    imem_bus_if.master  mem
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned UW = CW + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned VW = PARCEL_SIZE / 16;

    // PC queue: one entry per request issued and not yet answered
    logic [XLEN-1:0]        pcq_pc_q  [DEPTH];
    logic                   pcq_mis_q [DEPTH];
    logic [PW-1:0]          pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

    // Data FIFO: answered responses waiting for the core
    logic [PARCEL_SIZE-1:0] fd_data_q [DEPTH];
    logic [XLEN-1:0]        fd_pc_q   [DEPTH];
    logic                   fd_mis_q  [DEPTH];
    logic                   fd_pf_q   [DEPTH];
    logic [PW-1:0]          fd_wr_q, fd_wr_d, fd_rd_q, fd_rd_d;
    logic [CW-1:0]          fd_cnt_q, fd_cnt_d;

    logic [CW-1:0]          outst_q, outst_d;
    logic [CW-1:0]          disc_q, disc_d;
    logic                   run_q;

    logic [UW-1:0]          used;
    logic                   credit, req, accept, misal_in;
    logic                   ack_any, ack_drop, ack_take;
    logic                   fifo_empty, bypass, head_valid, push, pop;
    logic [PARCEL_SIZE-1:0] head_data;
    logic [XLEN-1:0]        head_pc;
    logic                   head_mis, head_pf;

    // Request side: credit covers in-flight, to-be-discarded and buffered entries
    assign used     = UW'(outst_q) + UW'(disc_q) + UW'(fd_cnt_q);
    assign credit   = (used < UW'(DEPTH));
    assign req      = run_q & credit & ~fetch.if_flush;
    assign accept   = req & ~mem.mem_stall;
    assign misal_in = (HAS_RVC != 0) ? fetch.if_nxt_pc[0] : |fetch.if_nxt_pc[1:0];

    assign mem.mem_req            = req;
    assign mem.mem_adr            = {fetch.if_nxt_pc[XLEN-1:2], 2'b00};
    assign fetch.if_stall_nxt_pc  = ~req | mem.mem_stall;

    // Response side: stale responses after a flush are dropped, others are kept
    assign ack_any    = mem.mem_ack & ((disc_q != '0) | (outst_q != '0));
    assign ack_drop   = mem.mem_ack & (disc_q != '0);
    assign ack_take   = mem.mem_ack & (disc_q == '0) & (outst_q != '0) & ~fetch.if_flush;
    assign fifo_empty = (fd_cnt_q == '0);

`ifdef IMEM_PREFETCH_BYPASS_EN
    assign bypass = fifo_empty & ack_take;
`else
    assign bypass = 1'b0;
`endif

    assign head_valid = ~fifo_empty | bypass;
    assign pop        = ~fifo_empty & ~fetch.if_stall;
    assign push       = ack_take & ~(bypass & ~fetch.if_stall);

    // Head selection: bypassed response or registered FIFO head, zero when empty
    always_comb begin
        head_data = '0;
        head_pc   = '0;
        head_mis  = 1'b0;
        head_pf   = 1'b0;
        if (bypass) begin
            head_data = mem.mem_q;
            head_pc   = pcq_pc_q[pcq_rd_q];
            head_mis  = pcq_mis_q[pcq_rd_q];
            head_pf   = mem.mem_page_fault;
        end else if (!fifo_empty) begin
            head_data = fd_data_q[fd_rd_q];
            head_pc   = fd_pc_q[fd_rd_q];
            head_mis  = fd_mis_q[fd_rd_q];
            head_pf   = fd_pf_q[fd_rd_q];
        end
    end

    assign fetch.if_parcel            = head_data;
    assign fetch.if_parcel_pc         = head_pc;
    assign fetch.if_parcel_valid      = {VW{head_valid}};
    assign fetch.if_parcel_misaligned = head_mis;
    assign fetch.if_parcel_page_fault = head_pf;

    // Next-state for pointers and counters; flush empties both queues
    always_comb begin
        pcq_wr_d = pcq_wr_q;
        pcq_rd_d = pcq_rd_q;
        fd_wr_d  = fd_wr_q;
        fd_rd_d  = fd_rd_q;
        fd_cnt_d = fd_cnt_q;
        outst_d  = outst_q;
        disc_d   = disc_q;
        if (fetch.if_flush) begin
            pcq_wr_d = '0;
            pcq_rd_d = '0;
            fd_wr_d  = '0;
            fd_rd_d  = '0;
            fd_cnt_d = '0;
            outst_d  = '0;
            disc_d   = disc_q + outst_q - CW'(ack_any);
        end else begin
            pcq_wr_d = pcq_wr_q + PW'(accept);
            pcq_rd_d = pcq_rd_q + PW'(ack_take);
            outst_d  = outst_q + CW'(accept) - CW'(ack_take);
            disc_d   = disc_q - CW'(ack_drop);
            fd_wr_d  = fd_wr_q + PW'(push);
            fd_rd_d  = fd_rd_q + PW'(pop);
            fd_cnt_d = fd_cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
            fd_wr_q  <= '0;
            fd_rd_q  <= '0;
            fd_cnt_q <= '0;
            outst_q  <= '0;
            disc_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            pcq_wr_q <= pcq_wr_d;
            pcq_rd_q <= pcq_rd_d;
            fd_wr_q  <= fd_wr_d;
            fd_rd_q  <= fd_rd_d;
            fd_cnt_q <= fd_cnt_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            run_q    <= 1'b1;
        end
    end

    // Queue storage; contents are only observed through valid pointers
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_pc_q[pcq_wr_q]  <= fetch.if_nxt_pc;
            pcq_mis_q[pcq_wr_q] <= misal_in;
        end
        if (push && !fetch.if_flush) begin
            fd_data_q[fd_wr_q] <= mem.mem_q;
            fd_pc_q[fd_wr_q]   <= pcq_pc_q[pcq_rd_q];
            fd_mis_q[fd_wr_q]  <= pcq_mis_q[pcq_rd_q];
            fd_pf_q[fd_wr_q]   <= mem.mem_page_fault;
        end
    end

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed testbench for imem_prefetch_buffer (DEPTH=4, HAS_RVC=0).
`timescale 1ns/1ps
module tb_imem_prefetch_buffer;
    logic clk = 1'b0;
    logic rstn;

    imem_fetch_if #(.XLEN(32), .PARCEL_SIZE(32)) f();
    imem_bus_if   #(.XLEN(32), .PARCEL_SIZE(32)) b();

    imem_prefetch_buffer #(
        .XLEN(32), .PARCEL_SIZE(32), .DEPTH(4), .HAS_RVC(0)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .fetch (f),
        .mem   (b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] core_pc  = '0;
    logic        auto_pc  = 1'b0;
    logic        mem_auto = 1'b0;
    logic        man_ack  = 1'b0;
    logic [31:0] man_q    = '0;
    logic        man_pf   = 1'b0;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_q   = '0;
    logic        auto_pf  = 1'b0;
    logic [31:0] pf_addr  = '1;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    logic        acc_neg  = 1'b0;

    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];
    logic        log_mis[$];
    logic        log_pf[$];
    int          log_cyc[$];

    assign f.if_nxt_pc       = core_pc;
    assign b.mem_ack         = mem_auto ? auto_ack : man_ack;
    assign b.mem_q           = mem_auto ? auto_q   : man_q;
    assign b.mem_page_fault  = mem_auto ? auto_pf  : man_pf;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5EED_0000 ^ {a[15:0], 16'h0000};
    endfunction

    // Memory model: answers every accepted request exactly one cycle later
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        auto_ack <= rstn & b.mem_req & ~b.mem_stall;
        auto_q   <= mdata(b.mem_adr);
        auto_pf  <= rstn & b.mem_req & ~b.mem_stall & (b.mem_adr == pf_addr);
    end

    // Observer: records accepted requests and parcels consumed by the core
    always @(negedge clk) begin
        acc_neg = rstn & b.mem_req & ~b.mem_stall;
        if (acc_neg) acc_cnt++;
        if (rstn && (f.if_parcel_valid != 2'b00) && !f.if_stall) begin
            log_pc.push_back(f.if_parcel_pc);
            log_data.push_back(f.if_parcel);
            log_mis.push_back(f.if_parcel_misaligned);
            log_pf.push_back(f.if_parcel_page_fault);
            log_cyc.push_back(cyc);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_pc && acc_neg) core_pc = core_pc + 32'd4;
    endtask

    task automatic idle_inputs();
        f.if_stall  = 1'b0;
        f.if_flush  = 1'b0;
        b.mem_stall = 1'b1;
        mem_auto    = 1'b0;
        man_ack     = 1'b0;
        man_q       = '0;
        man_pf      = 1'b0;
        auto_pc     = 1'b0;
        core_pc     = '0;
        pf_addr     = '1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        int a0;
        int n0;
        rstn = 1'b1;
        idle_inputs();
        #1 rstn = 1'b0;
        cycle();
        cycle();
        checks++; if (f.if_parcel_valid !== 2'b00) begin fails++; $display("FAIL reset_valid got=%b exp=00", f.if_parcel_valid); end
        checks++; if (b.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%b exp=0", b.mem_req); end
        checks++; if (f.if_stall_nxt_pc !== 1'b1) begin fails++; $display("FAIL reset_stall_nxt_pc got=%b exp=1", f.if_stall_nxt_pc); end
        checks++; if (f.if_parcel !== 32'h0 || f.if_parcel_pc !== 32'h0) begin fails++; $display("FAIL reset_parcel got=%h/%h exp=0/0", f.if_parcel, f.if_parcel_pc); end
        checks++; if (f.if_parcel_misaligned !== 1'b0 || f.if_parcel_page_fault !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", f.if_parcel_misaligned, f.if_parcel_page_fault); end

        // build up three outstanding requests with no responses
        rstn = 1'b1;
        b.mem_stall = 1'b0;
        f.if_stall  = 1'b1;
        core_pc = 32'h100;
        auto_pc = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < 12 && (acc_cnt - a0) < 3; i++) cycle();
        checks++; if (acc_cnt - a0 != 3) begin fails++; $display("FAIL burst_accepts got=%0d exp=3", acc_cnt - a0); end

        rstn = 1'b0;
        #1;
        checks++; if (b.mem_req !== 1'b0) begin fails++; $display("FAIL midreset_mem_req got=%b exp=0", b.mem_req); end
        checks++; if (f.if_stall_nxt_pc !== 1'b1) begin fails++; $display("FAIL midreset_stall_nxt_pc got=%b exp=1", f.if_stall_nxt_pc); end
        checks++; if (f.if_parcel_valid !== 2'b00) begin fails++; $display("FAIL midreset_valid got=%b exp=00", f.if_parcel_valid); end

        // stale responses after reset must be ignored
        cycle();
        auto_pc = 1'b0;
        b.mem_stall = 1'b1;
        f.if_stall  = 1'b0;
        rstn    = 1'b1;
        man_ack = 1'b1;
        man_q   = 32'hBAD0_0000;
        repeat (3) cycle();
        man_ack = 1'b0;
        #1;
        checks++; if (f.if_parcel_valid !== 2'b00) begin fails++; $display("FAIL stale_ack_valid got=%b exp=00", f.if_parcel_valid); end

        n0 = log_pc.size();
        core_pc  = 32'h200;
        auto_pc  = 1'b1;
        mem_auto = 1'b1;
        b.mem_stall = 1'b0;
        for (int i = 0; i < 20 && log_pc.size() == n0; i++) cycle();
        b.mem_stall = 1'b1;
        repeat (4) cycle();
        checks++;
        if (log_pc.size() <= n0) begin
            fails++; $display("FAIL post_reset_parcel got=none exp=pc 00000200");
        end else if (log_pc[n0] !== 32'h200 || log_data[n0] !== mdata(32'h200)) begin
            fails++; $display("FAIL post_reset_parcel got=%h/%h exp=00000200/%h", log_pc[n0], log_data[n0], mdata(32'h200));
        end
    endtask

    task automatic test_streaming();
        int a0;
        int n0;
        int n;
        apply_reset();
        a0 = acc_cnt;
        n0 = log_pc.size();
        core_pc  = 32'h200;
        auto_pc  = 1'b1;
        mem_auto = 1'b1;
        b.mem_stall = 1'b0;
        repeat (10) cycle();
        b.mem_stall = 1'b1;
        repeat (6) cycle();
        n = log_pc.size() - n0;
        checks++; if (acc_cnt - a0 != 10) begin fails++; $display("FAIL stream_accepts got=%0d exp=10", acc_cnt - a0); end
        checks++; if (n != 10) begin fails++; $display("FAIL stream_parcels got=%0d exp=10", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (log_pc[n0+k] !== 32'h200 + 32'(4*k) || log_data[n0+k] !== mdata(32'h200 + 32'(4*k))) begin
                fails++; $display("FAIL stream_parcel_%0d got=%h/%h exp=%h", k, log_pc[n0+k], log_data[n0+k], 32'h200 + 32'(4*k));
            end
            if (k > 0) begin
                checks++;
                if (log_cyc[n0+k] != log_cyc[n0+k-1] + 1) begin
                    fails++; $display("FAIL stream_rate_%0d got=%0d exp=%0d", k, log_cyc[n0+k], log_cyc[n0+k-1] + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int a0;
        int n0;
        int n;
        int acc;
        apply_reset();
        a0 = acc_cnt;
        n0 = log_pc.size();
        f.if_stall = 1'b1;
        core_pc  = 32'h200;
        auto_pc  = 1'b1;
        mem_auto = 1'b1;
        b.mem_stall = 1'b0;
        repeat (8) cycle();
        checks++; if (acc_cnt - a0 != 4) begin fails++; $display("FAIL bp_accepts got=%0d exp=4", acc_cnt - a0); end
        checks++; if (b.mem_req !== 1'b0) begin fails++; $display("FAIL bp_mem_req got=%b exp=0", b.mem_req); end
        checks++; if (f.if_stall_nxt_pc !== 1'b1) begin fails++; $display("FAIL bp_stall_nxt_pc got=%b exp=1", f.if_stall_nxt_pc); end
        checks++; if (f.if_parcel_valid !== 2'b11 || f.if_parcel_pc !== 32'h200) begin fails++; $display("FAIL bp_head got=%b/%h exp=11/00000200", f.if_parcel_valid, f.if_parcel_pc); end
        checks++; if (log_pc.size() != n0) begin fails++; $display("FAIL bp_no_consume got=%0d exp=0", log_pc.size() - n0); end

        f.if_stall = 1'b0;
        repeat (10) cycle();
        b.mem_stall = 1'b1;
        repeat (8) cycle();
        acc = acc_cnt - a0;
        n   = log_pc.size() - n0;
        checks++; if (acc <= 4) begin fails++; $display("FAIL bp_resume got=%0d exp=>4", acc); end
        checks++; if (n != acc) begin fails++; $display("FAIL bp_count got=%0d exp=%0d", n, acc); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (log_pc[n0+k] !== 32'h200 + 32'(4*k) || log_data[n0+k] !== mdata(32'h200 + 32'(4*k))) begin
                fails++; $display("FAIL bp_parcel_%0d got=%h/%h exp=%h", k, log_pc[n0+k], log_data[n0+k], 32'h200 + 32'(4*k));
            end
        end
    endtask

    task automatic test_flush();
        int a0;
        int n0;
        apply_reset();
        a0 = acc_cnt;
        n0 = log_pc.size();
        core_pc = 32'h100;
        auto_pc = 1'b1;
        b.mem_stall = 1'b0;
        for (int i = 0; i < 12 && (acc_cnt - a0) < 3; i++) cycle();
        checks++; if (acc_cnt - a0 != 3) begin fails++; $display("FAIL flush_setup got=%0d exp=3", acc_cnt - a0); end

        // flush cycle: one old response lands here and must also be dropped
        auto_pc   = 1'b0;
        core_pc   = 32'h300;
        f.if_flush = 1'b1;
        man_ack   = 1'b1;
        man_q     = 32'hBAD0_0001;
        #1;
        checks++; if (b.mem_req !== 1'b0 || f.if_stall_nxt_pc !== 1'b1) begin fails++; $display("FAIL flush_no_req got=%b/%b exp=0/1", b.mem_req, f.if_stall_nxt_pc); end
        cycle();
        f.if_flush = 1'b0;
        man_q = 32'hBAD0_0002;
        #1;
        checks++; if (f.if_parcel_valid !== 2'b00) begin fails++; $display("FAIL flush_valid got=%b exp=00", f.if_parcel_valid); end
        checks++; if (b.mem_req !== 1'b1) begin fails++; $display("FAIL flush_new_req got=%b exp=1", b.mem_req); end
        cycle();
        b.mem_stall = 1'b1;
        man_q = 32'hBAD0_0003;
        cycle();
        man_q = mdata(32'h300);
        cycle();
        man_ack = 1'b0;
        repeat (3) cycle();
        checks++; if (acc_cnt - a0 != 4) begin fails++; $display("FAIL flush_accepts got=%0d exp=4", acc_cnt - a0); end
        checks++;
        if (log_pc.size() - n0 != 1) begin
            fails++; $display("FAIL flush_parcels got=%0d exp=1", log_pc.size() - n0);
        end else if (log_pc[n0] !== 32'h300 || log_data[n0] !== mdata(32'h300)) begin
            fails++; $display("FAIL flush_first_parcel got=%h/%h exp=00000300/%h", log_pc[n0], log_data[n0], mdata(32'h300));
        end
    endtask

    task automatic test_faults();
        int n0;
        apply_reset();
        n0 = log_pc.size();
        mem_auto = 1'b1;
        pf_addr  = 32'h204;
        core_pc  = 32'h202;
        b.mem_stall = 1'b0;
        #1;
        checks++; if (b.mem_adr !== 32'h200) begin fails++; $display("FAIL fault_adr_align got=%h exp=00000200", b.mem_adr); end
        cycle();
        core_pc = 32'h204;
        cycle();
        core_pc = 32'h208;
        cycle();
        b.mem_stall = 1'b1;
        repeat (5) cycle();
        checks++;
        if (log_pc.size() - n0 != 3) begin
            fails++; $display("FAIL fault_parcels got=%0d exp=3", log_pc.size() - n0);
        end else begin
            checks++; if (log_pc[n0] !== 32'h202 || log_data[n0] !== mdata(32'h200) || log_mis[n0] !== 1'b1 || log_pf[n0] !== 1'b0)
                begin fails++; $display("FAIL fault_misaligned got=%h/%h mis=%b pf=%b exp=00000202 mis=1 pf=0", log_pc[n0], log_data[n0], log_mis[n0], log_pf[n0]); end
            checks++; if (log_pc[n0+1] !== 32'h204 || log_mis[n0+1] !== 1'b0 || log_pf[n0+1] !== 1'b1)
                begin fails++; $display("FAIL fault_page got=%h mis=%b pf=%b exp=00000204 mis=0 pf=1", log_pc[n0+1], log_mis[n0+1], log_pf[n0+1]); end
            checks++; if (log_pc[n0+2] !== 32'h208 || log_mis[n0+2] !== 1'b0 || log_pf[n0+2] !== 1'b0)
                begin fails++; $display("FAIL fault_clean got=%h mis=%b pf=%b exp=00000208 mis=0 pf=0", log_pc[n0+2], log_mis[n0+2], log_pf[n0+2]); end
        end
    endtask

    task automatic test_latency();
        int a0;
        logic [1:0] exp_m;
        logic [1:0] exp_m1;
`ifdef IMEM_PREFETCH_BYPASS_EN
        exp_m  = 2'b11;
        exp_m1 = 2'b00;
`else
        exp_m  = 2'b00;
        exp_m1 = 2'b11;
`endif
        apply_reset();
        a0 = acc_cnt;
        core_pc = 32'h400;
        b.mem_stall = 1'b0;
        cycle();
        b.mem_stall = 1'b1;
        man_ack = 1'b1;
        man_q   = mdata(32'h400);
        #1;
        checks++; if (acc_cnt - a0 != 1) begin fails++; $display("FAIL lat_accept got=%0d exp=1", acc_cnt - a0); end
        checks++; if (f.if_parcel_valid !== exp_m) begin fails++; $display("FAIL lat_ack_cycle_valid got=%b exp=%b", f.if_parcel_valid, exp_m); end
        if (exp_m == 2'b11) begin
            checks++; if (f.if_parcel_pc !== 32'h400 || f.if_parcel !== mdata(32'h400)) begin fails++; $display("FAIL lat_bypass_data got=%h/%h exp=00000400/%h", f.if_parcel_pc, f.if_parcel, mdata(32'h400)); end
        end
        cycle();
        man_ack = 1'b0;
        #1;
        checks++; if (f.if_parcel_valid !== exp_m1) begin fails++; $display("FAIL lat_next_cycle_valid got=%b exp=%b", f.if_parcel_valid, exp_m1); end
        if (exp_m1 == 2'b11) begin
            checks++; if (f.if_parcel_pc !== 32'h400 || f.if_parcel !== mdata(32'h400)) begin fails++; $display("FAIL lat_reg_data got=%h/%h exp=00000400/%h", f.if_parcel_pc, f.if_parcel, mdata(32'h400)); end
        end
        cycle();
        #1;
        checks++; if (f.if_parcel_valid !== 2'b00) begin fails++; $display("FAIL lat_drained got=%b exp=00", f.if_parcel_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_faults();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
